kmp_pe_scheduler: RTL
=====================

// Module: kmp_pe_scheduler
// PURPOSE
//  Sequences NUM_PE parallel KMP_pe instances over one loaded string/pattern pair.
//  On shared_memory's valid pulse it partitions the string into overlapping segments
//  and starts each PE on its segment. It collects the per-PE results and drives the
//  SME-level valid/match/match_index with the lowest matching string index.
// PARAMETERS
//  NUM_PE     4  number of KMP_pe instances; power of two, >=2
//  LOG_PE     2  log2(NUM_PE)
//  STR_ADD_W  5  string index width (`MAX_STR_ADD)
//  PAT_ADD_W  3  pattern index width (`MAX_PAT_ADD)
// PORTS
//  clk          in   1                  rising-edge clock
//  reset        in   1                  asynchronous, active-low reset
//  input_valid  in   1                  1-cycle pulse: string+pattern loaded
//  str_last_idx in   STR_ADD_W          index of last string char
//  pat_last_idx in   PAT_ADD_W          index of last pattern char
//  pe_start     out  NUM_PE             1-cycle start pulse per PE
//  pe_start_idx out  NUM_PE*STR_ADD_W   segment first index; PE k at [k*W +: W]
//  pe_end_idx   out  NUM_PE*STR_ADD_W   segment last index (PE process_2idx)
//  pe_done      in   NUM_PE             1-cycle done pulse per PE (PE output_valid)
//  pe_match     in   NUM_PE             PE found a match; sampled with pe_done
//  pe_match_idx in   NUM_PE*STR_ADD_W   PE first match index; sampled with pe_done
//  busy         out  1                  high in every state except IDLE
//  valid        out  1                  1-cycle result strobe
//  match        out  1                  a match exists; meaningful when valid=1
//  match_index  out  STR_ADD_W          lowest match index; 0 when match=0
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, done_mask/match regs cleared, including mid-operation.
//  FSM: IDLE -(input_valid)-> CALC -> DISPATCH -> WAIT -(all done)-> REPORT -> IDLE.
//   CALC: latch S=str_last_idx, P=pat_last_idx.
//    seg_len = (S+1+NUM_PE-1)>>LOG_PE, computed in STR_ADD_W+1 bits.
//    PE k: start_k = k*seg_len; end_k = min(start_k+seg_len-1+P, S).
//    Overlap of P chars means a match straddling a boundary is found by the earlier PE.
//    PE k is active iff start_k+P <= S (wide compare, no wrap).
//    done_mask is preset to 1 for inactive PEs.
//    pe_start_idx/pe_end_idx are registered here and held stable until the next CALC.
//   DISPATCH: pe_start[k]=1 for active PEs only, for exactly one cycle.
//    If P > S, no PE is active: skip to REPORT with match=0.
//   WAIT: each cycle, for every k with pe_done[k]=1:
//    - set done_mask[k];
//    - if pe_match[k], update best: best = min(best, pe_match_idx[k]).
//    Several simultaneous done pulses are all absorbed in the same cycle.
//    pe_done on an inactive PE, or a repeat pulse on an already-done PE, is ignored.
//    Exit when done_mask is all ones, counting the current cycle's pulses.
//   REPORT: valid=1 for one cycle, with match=any_match and match_index=best (0 if none).
//  Latency: the valid strobe is 1 cycle after WAIT observes the final pe_done.
//   Minimum input_valid-to-valid delay is CALC+DISPATCH+PE latency+2.
//  input_valid while busy=1 is dropped; no queueing.
//   The loader only pulses input_valid again after valid.
//  Tie on equal match index from two PEs (overlap region): the single value is reported.
//  Indices never wrap: end_k saturates at S; S=2^STR_ADD_W-1 is handled with the +1 bit.
// TESTING
//  1 S=31,P=3,NUM_PE=4 -> seg_len=8; ranges 0..10, 8..18, 16..26, 24..31; all 4 pe_start pulse.
//  2 Case 1; PE2 done match@20, PE0 done match@9 two cycles later, others no match
//    -> valid one cycle after the last done, match=1, match_index=9.
//  3 S=4,P=1 -> ranges PE0 0..2, PE1 2..4; PE2/PE3 inactive, no start pulse;
//    valid after the PE0+PE1 done pulses only.
//  4 S=2,P=4 -> no pe_start; valid 3 cycles after input_valid with match=0, match_index=0.
//  5 All 4 pe_done in the same cycle, matches@{27,12,-,12} -> one valid, match_index=12;
//    repeat done pulses are ignored.
//  6 Assert reset low during WAIT -> all outputs 0 immediately; the next input_valid runs a clean job;
//    input_valid while busy has no effect.

Source files
------------

// File: rtl/kmp_pe_scheduler_if.sv
// kmp_pe_scheduler_if
//  Bundles the loader handshake, the per-PE start/done bus and the
//  SME-level result strobe of kmp_pe_scheduler.
//  master : loader + PE array side (drives job inputs and PE results)
//  slave  : scheduler side (drives PE starts, segment ranges and result)
//  Signals:
//   input_valid/str_last_idx/pat_last_idx  job request
//   pe_start/pe_start_idx/pe_end_idx       per-PE dispatch (PE k at [k*W +: W])
//   pe_done/pe_match/pe_match_idx          per-PE completion
//   busy/valid/match/match_index           scheduler status and result
interface kmp_pe_scheduler_if #(
    parameter int NUM_PE    = 4,
    parameter int STR_ADD_W = 5,
    parameter int PAT_ADD_W = 3
);
    logic                          input_valid;
    logic [STR_ADD_W-1:0]          str_last_idx;
    logic [PAT_ADD_W-1:0]          pat_last_idx;
    logic [NUM_PE-1:0]             pe_start;
    logic [NUM_PE*STR_ADD_W-1:0]   pe_start_idx;
    logic [NUM_PE*STR_ADD_W-1:0]   pe_end_idx;
    logic [NUM_PE-1:0]             pe_done;
    logic [NUM_PE-1:0]             pe_match;
    logic [NUM_PE*STR_ADD_W-1:0]   pe_match_idx;
    logic                          busy;
    logic                          valid;
    logic                          match;
    logic [STR_ADD_W-1:0]          match_index;

    modport master (
        output input_valid, str_last_idx, pat_last_idx,
        output pe_done, pe_match, pe_match_idx,
        input  pe_start, pe_start_idx, pe_end_idx,
        input  busy, valid, match, match_index
    );

    modport slave (
        input  input_valid, str_last_idx, pat_last_idx,
        input  pe_done, pe_match, pe_match_idx,
        output pe_start, pe_start_idx, pe_end_idx,
        output busy, valid, match, match_index
    );
endinterface

// File: rtl/kmp_pe_scheduler.sv
// kmp_pe_scheduler
//  Splits one loaded string into NUM_PE overlapping segments, starts a KMP PE
//  on each non-empty segment, gathers the PE results and reports the lowest
//  matching string index.
//  Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    kmp_pe_scheduler_if.slave (job request, PE dispatch/done, result)
module kmp_pe_scheduler #(
    parameter int NUM_PE    = 4,
    parameter int LOG_PE    = 2,
    parameter int STR_ADD_W = 5,
    parameter int PAT_ADD_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    kmp_pe_scheduler_if.slave       bus
);
    // Wide enough that k*seg_len, start+seg_len-1+P never wrap.
    localparam int XW = STR_ADD_W + LOG_PE + 2;

    typedef enum logic [2:0] {IDLE, CALC, DISPATCH, WAIT, REPORT} state_t;

    state_t                        state, state_nxt;
    logic [STR_ADD_W-1:0]          s_q;
    logic [PAT_ADD_W-1:0]          p_q;
    logic [NUM_PE-1:0]             active_q;
    logic [NUM_PE-1:0]             done_mask;
    logic                          any_match;
    logic [STR_ADD_W-1:0]          best;
    logic [NUM_PE*STR_ADD_W-1:0]   start_q, end_q;

    // Segment partition from the latched S/P
    logic [XW-1:0]                 seg_len, st, en;
    logic [NUM_PE-1:0]             active_c;
    logic [NUM_PE*STR_ADD_W-1:0]   start_c, end_c;

    always_comb begin
        seg_len  = (XW'(s_q) + XW'(NUM_PE)) >> LOG_PE;
        active_c = '0;
        start_c  = '0;
        end_c    = '0;
        st       = '0;
        en       = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            st = XW'(k) * seg_len;
            en = st + seg_len - XW'(1) + XW'(p_q);
            if (en > XW'(s_q))
                en = XW'(s_q);
            active_c[k] = (st + XW'(p_q)) <= XW'(s_q);
            start_c[k*STR_ADD_W +: STR_ADD_W] = st[STR_ADD_W-1:0];
            end_c[k*STR_ADD_W +: STR_ADD_W]   = en[STR_ADD_W-1:0];
        end
    end

    // Result collection: only the first done pulse of an active PE counts
    // (inactive PEs are preset in done_mask, so they are masked here too).
    logic [NUM_PE-1:0]             new_done, hit;
    logic [STR_ADD_W-1:0]          wait_best;
    logic                          all_done;

    always_comb begin
        new_done  = bus.pe_done & ~done_mask;
        hit       = new_done & bus.pe_match;
        all_done  = &(done_mask | bus.pe_done);
        wait_best = best;
        for (int k = 0; k < NUM_PE; k++) begin
            if (hit[k] && (bus.pe_match_idx[k*STR_ADD_W +: STR_ADD_W] < wait_best))
                wait_best = bus.pe_match_idx[k*STR_ADD_W +: STR_ADD_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.input_valid) state_nxt = CALC;
            CALC:     state_nxt = DISPATCH;
            DISPATCH: state_nxt = (|active_q) ? WAIT : REPORT;
            WAIT:     if (all_done) state_nxt = REPORT;
            REPORT:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q       <= '0;
            p_q       <= '0;
            active_q  <= '0;
            done_mask <= '0;
            any_match <= 1'b0;
            best      <= '0;
            start_q   <= '0;
            end_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.input_valid) begin
                        s_q <= bus.str_last_idx;
                        p_q <= bus.pat_last_idx;
                    end
                end
                CALC: begin
                    start_q   <= start_c;
                    end_q     <= end_c;
                    active_q  <= active_c;
                    done_mask <= ~active_c;
                    any_match <= 1'b0;
                    best      <= '1;
                end
                WAIT: begin
                    done_mask <= done_mask | new_done;
                    any_match <= any_match | (|hit);
                    best      <= wait_best;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.pe_start     = (state == DISPATCH) ? active_q : '0;
    assign bus.pe_start_idx = start_q;
    assign bus.pe_end_idx   = end_q;
    assign bus.valid        = (state == REPORT);
    assign bus.match        = (state == REPORT) && any_match;
    assign bus.match_index  = ((state == REPORT) && any_match) ? best : '0;
endmodule
